// File: rtl/fir_engine_param.sv
// Parametrised FIR engine: AXI-Lite programmed coefficients and tap count, AXI-Stream
// sample in/out, internal circular history, optional output saturation and tlast check.
module fir_engine_param #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pMAX_TAPS   = 32,
   parameter int pSAT        = 0
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   output logic                   wready,
   input  logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   arvalid,
   output logic                   arready,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [pDATA_WIDTH-1:0] rdata,
   input  logic                   ss_tvalid,
   output logic                   ss_tready,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   sm_tvalid,
   input  logic                   sm_tready,
   output logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tlast
);
   localparam int LG = $clog2(pMAX_TAPS);
   localparam int PW = 2 * pDATA_WIDTH;
   localparam int AW = PW + LG;
   localparam int TW = LG + 1;

   localparam logic [pADDR_WIDTH-1:0] A_CTRL   = '0;
   localparam logic [pADDR_WIDTH-1:0] A_LEN    = pADDR_WIDTH'(16);
   localparam logic [pADDR_WIDTH-1:0] A_TAP    = pADDR_WIDTH'(20);
   localparam logic [pADDR_WIDTH-1:0] A_COEF   = pADDR_WIDTH'(128);
   localparam logic [pADDR_WIDTH-1:0] A_COEF_E = pADDR_WIDTH'(128 + 4 * pMAX_TAPS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_MAC, S_OUT} state_t;

   state_t                  state_q, state_d;
   logic [pDATA_WIDTH-1:0]  coef_q [pMAX_TAPS];
   logic [pDATA_WIDTH-1:0]  hist_q [pMAX_TAPS];
   logic [pDATA_WIDTH-1:0]  len_q, tap_q, cnt_q;
   logic [LG-1:0]           head_q;
   logic [TW-1:0]           k_q;
   logic signed [PW-1:0]    prod_q;
   logic signed [AW-1:0]    acc_q;
   logic                    done_q, done_d, err_q, err_d;
   logic                    aw_rdy_q, ar_rdy_q, rvalid_q;
   logic [pDATA_WIDTH-1:0]  rdata_q, rd_val;

   logic                    is_idle, is_last, wr_en, ar_hs, ss_hs, sm_hs;
   logic                    start_go, start_run, wr_coef, rd_ctrl, done_set, err_set;
   logic [TW-1:0]           n_eff;
   logic [pDATA_WIDTH-1:0]  y_out;

   function automatic logic coef_hit(input logic [pADDR_WIDTH-1:0] a);
      return (a[1:0] == 2'b00) && (a >= A_COEF) && (a < A_COEF_E);
   endfunction

   function automatic logic [LG-1:0] coef_idx(input logic [pADDR_WIDTH-1:0] a);
      logic [pADDR_WIDTH-1:0] off;
      off = (a - A_COEF) >> 2;
      return LG'(off);
   endfunction

   assign is_idle   = (state_q == S_IDLE);
   assign is_last   = (cnt_q == len_q - 1'b1);
   assign wr_en     = aw_rdy_q && awvalid && wvalid;
   assign ar_hs     = ar_rdy_q && arvalid;
   assign ss_hs     = (state_q == S_WAIT_IN) && ss_tvalid;
   assign sm_hs     = (state_q == S_OUT) && sm_tready;
   assign start_go  = wr_en && is_idle && (awaddr == A_CTRL) && wdata[0];
   assign start_run = start_go && (len_q != '0);
   assign wr_coef   = wr_en && is_idle && coef_hit(awaddr);
   assign rd_ctrl   = ar_hs && (araddr == A_CTRL);
   assign done_set  = (sm_hs && is_last) || (start_go && (len_q == '0));
   assign err_set   = ss_hs && (ss_tlast != is_last);
   // A flag set on the same edge as a clearing read wins over the clear.
   assign done_d    = done_set || (done_q && !rd_ctrl);
   assign err_d     = err_set || (err_q && !rd_ctrl);

   always_comb begin
      if (tap_q == '0)
         n_eff = TW'(1);
      else if (tap_q > pDATA_WIDTH'(pMAX_TAPS))
         n_eff = TW'(pMAX_TAPS);
      else
         n_eff = tap_q[TW-1:0];
   end

   generate
      if (pSAT != 0) begin : g_sat
         localparam logic signed [AW-1:0] MAXV = {{(AW-pDATA_WIDTH+1){1'b0}}, {(pDATA_WIDTH-1){1'b1}}};
         localparam logic signed [AW-1:0] MINV = {{(AW-pDATA_WIDTH+1){1'b1}}, {(pDATA_WIDTH-1){1'b0}}};
         always_comb begin
            if (acc_q > MAXV)
               y_out = {1'b0, {(pDATA_WIDTH-1){1'b1}}};
            else if (acc_q < MINV)
               y_out = {1'b1, {(pDATA_WIDTH-1){1'b0}}};
            else
               y_out = acc_q[pDATA_WIDTH-1:0];
         end
      end else begin : g_wrap
         assign y_out = acc_q[pDATA_WIDTH-1:0];
      end
   endgenerate

   always_ff @(posedge axis_clk) begin
      if (axis_rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_run) state_d = S_WAIT_IN;
         S_WAIT_IN: if (ss_tvalid) state_d = S_MAC;
         S_MAC:     if (k_q == n_eff) state_d = S_OUT;
         S_OUT:     if (sm_tready) state_d = is_last ? S_IDLE : S_WAIT_IN;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ss_tready = 1'b0;
      sm_tvalid = 1'b0;
      sm_tlast  = 1'b0;
      sm_tdata  = '0;
      case (state_q)
         S_WAIT_IN: ss_tready = 1'b1;
         S_OUT: begin
            sm_tvalid = 1'b1;
            sm_tlast  = is_last;
            sm_tdata  = y_out;
         end
         default: ;
      endcase
   end

   // Product is registered; the accumulate trails it by one cycle, so k_q runs 0..N.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         len_q  <= '0;
         tap_q  <= '0;
         cnt_q  <= '0;
         head_q <= '0;
         k_q    <= '0;
         prod_q <= '0;
         acc_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= done_d;
         err_q  <= err_d;
         if (wr_en && is_idle && (awaddr == A_LEN))
            len_q <= wdata;
         if (wr_en && is_idle && (awaddr == A_TAP))
            tap_q <= wdata;
         case (state_q)
            S_IDLE: begin
               if (start_run) begin
                  cnt_q  <= '0;
                  head_q <= '0;
               end
            end
            S_WAIT_IN: begin
               if (ss_tvalid) begin
                  acc_q <= '0;
                  k_q   <= '0;
               end
            end
            S_MAC: begin
               if (k_q != n_eff) begin
                  prod_q <= $signed(coef_q[k_q[LG-1:0]]) * $signed(hist_q[LG'(head_q - k_q[LG-1:0])]);
                  k_q    <= k_q + 1'b1;
               end
               if (k_q != '0)
                  acc_q <= acc_q + {{LG{prod_q[PW-1]}}, prod_q};
            end
            S_OUT: begin
               if (sm_tready) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (!is_last)
                     head_q <= head_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge axis_clk) begin
      for (int i = 0; i < pMAX_TAPS; i++) begin
         if (axis_rst) begin
            coef_q[i] <= '0;
            hist_q[i] <= '0;
         end else begin
            if (wr_coef && (coef_idx(awaddr) == LG'(i)))
               coef_q[i] <= wdata;
            if (start_run)
               hist_q[i] <= '0;
            else if (ss_hs && (head_q == LG'(i)))
               hist_q[i] <= ss_tdata;
         end
      end
   end

   // Read mux sees pre-edge register contents, so a colliding write returns the old value.
   always_comb begin
      rd_val = '0;
      if (araddr == A_CTRL)
         rd_val = pDATA_WIDTH'({err_q || err_set, is_idle, done_q || done_set, 1'b0});
      else if (araddr == A_LEN)
         rd_val = len_q;
      else if (araddr == A_TAP)
         rd_val = tap_q;
      else if (coef_hit(araddr))
         rd_val = coef_q[coef_idx(araddr)];
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         aw_rdy_q <= 1'b0;
         ar_rdy_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         aw_rdy_q <= awvalid && wvalid && !aw_rdy_q;
         ar_rdy_q <= !(ar_hs || (rvalid_q && !rready));
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
         end else if (rvalid_q && rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   assign awready = aw_rdy_q;
   assign wready  = aw_rdy_q;
   assign arready = ar_rdy_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;

endmodule

// File: doc/fir_engine_param.md
# fir_engine_param

Parametrised, self-contained FIR filter engine for the FIR subsystem. Coefficients, tap count and data length are programmed over AXI-Lite. Samples stream in over AXI-Stream slave (`ss_*`) and results stream out over AXI-Stream master (`sm_*`). Compared with the fixed 32-tap/external-BRAM FIR, this block adds:
- internal coefficient and history storage;
- a runtime-selectable tap count up to `pMAX_TAPS`;
- optional output saturation;
- a sticky `ss_tlast` framing-error flag.

## Interface
- `pADDR_WIDTH`, 12: AXI-Lite address width.
- `pDATA_WIDTH`, 32: sample, coefficient and output width (signed).
- `pMAX_TAPS`, 32: maximum tap count (power of 2, 2..64).
- `pSAT`, 0: 0 = wrap output to low `pDATA_WIDTH` bits; 1 = saturate to signed range.
- `axis_clk`  in  1  single clock; all logic on rising edge.
- `axis_rst`  in  1  synchronous, active-high reset.
- `awvalid`/`awready`/`awaddr`  in/out/in  1/1/`pADDR_WIDTH`  write address.
- `wvalid`/`wready`/`wdata`  in/out/in  1/1/`pDATA_WIDTH`  write data.
- `arvalid`/`arready`/`araddr`  in/out/in  1/1/`pADDR_WIDTH`  read address.
- `rvalid`/`rready`/`rdata`  out/in/out  1/1/`pDATA_WIDTH`  read data.
- `ss_tvalid`/`ss_tready`/`ss_tdata`/`ss_tlast`  in/out/in/in  1/1/`pDATA_WIDTH`/1  input stream.
- `sm_tvalid`/`sm_tready`/`sm_tdata`/`sm_tlast`  out/in/out/out  1/1/`pDATA_WIDTH`/1  output stream.

## Operation
- Register map:
  - 0x00 `ap_ctrl`:
    - bit0 `ap_start`: write 1 to start; self-clears.
    - bit1 `ap_done`: sticky; cleared by a read of 0x00.
    - bit2 `ap_idle`.
    - bit3 `tlast_err`: sticky; cleared by a read of 0x00.
  - 0x10 `data_length` (32 b).
  - 0x14 `tap_num`. Effective value is clamped to 1..`pMAX_TAPS`; the register reads back as written.
  - 0x80+4k: coef k, for k < `pMAX_TAPS`.
  - Any other address reads 0; writes to it are dropped.
- Coefficient, `tap_num` and `data_length` writes are ignored while not idle. Reads are always served.
- `ap_start` behaviour:
  - Writing `ap_start` while not idle is ignored.
  - On `ap_start` in IDLE: zero the history buffer, reset the sample count and head pointer, go to WAIT_IN.
  - If `data_length`==0: set `ap_done` and stay in IDLE.
- FSM states: IDLE, WAIT_IN, MAC, OUT.
  - IDLE: `ap_idle`=1.
  - WAIT_IN: `ss_tready`=1. On handshake, write the sample at head into the circular buffer (depth `pMAX_TAPS`, wraps modulo `pMAX_TAPS`), clear the accumulator, go to MAC.
  - MAC: one multiply-accumulate per cycle for k=0..N-1 (N = effective `tap_num`): acc += coef[k]·x[head−k mod `pMAX_TAPS`]. Then go to OUT.
  - OUT: `sm_tvalid`=1, `sm_tlast`=(count==`data_length`−1). On handshake, count++. If last: set `ap_done`, go to IDLE. Otherwise advance head and go to WAIT_IN.
- Arithmetic:
  - Product is 2·`pDATA_WIDTH` signed.
  - Accumulator is 2·`pDATA_WIDTH`+log2(`pMAX_TAPS`) signed and never overflows.
  - Output with `pSAT`=0 is acc[`pDATA_WIDTH`−1:0]. With `pSAT`=1 it is acc clamped to [−2^(W−1), 2^(W−1)−1].
- Framing check: `tlast_err` is set if `ss_tlast`=1 on a sample that is not number `data_length`−1, or `ss_tlast`=0 on the last sample. Processing continues regardless.

## Timing
- Reset values:
  - all ready/valid outputs 0;
  - `rdata`, `sm_tdata`, `sm_tlast` = 0;
  - FSM state IDLE;
  - all coefficients, `data_length`, `tap_num`, history and flags = 0; `ap_idle`=1.
- Reset mid-operation aborts immediately to the reset values. No output is emitted afterwards.
- AXI-Lite write: `awready`=`wready`=1 for one cycle only when `awvalid`&&`wvalid` are both high. The register updates on that edge.
- AXI-Lite read:
  - `arready`=1 whenever `rvalid`=0.
  - `rvalid` rises the cycle after the ar handshake and holds `rdata` stable until `rready`.
  - A read issued in the same cycle as a write to the same address returns the old value.
- Latency: sample accepted at edge t gives `sm_tvalid` at edge t+N+1. Back-pressure on `sm_tready` holds the output stable indefinitely, and `ss_tready` stays 0 meanwhile.
- `ap_done` rises the cycle after the last sm handshake. `ap_idle` rises on the same edge.
- Clear-on-read precedence: if `ap_done` is set on the same edge as a read of 0x00, the read returns the new value and the flag stays set.

## Test plan
- Program taps = 4 and coef = {1,2,3,4}, `data_length`=5; stream 1..5 with correct tlast. Require:
  - outputs 1,4,10,20,30;
  - `sm_tlast` only on the 5th output;
  - 0x00 reads 0x6, then 0x4.
- Program `pMAX_TAPS`=32 coefficients; read back all 32. Each must match exactly. A write during a run is ignored (readback unchanged).
- `pSAT`=1, taps=2, coef={0x7FFFFFFF,0x7FFFFFFF}, inputs {2,2}. Require outputs 0x7FFFFFFF and 0x7FFFFFFF. With `pSAT`=0, require the wrapped values 0xFFFFFFFE and 0xFFFFFFFC.
- `tap_num`=0 written, reads 0; a run behaves as 1 tap: coef0=3, input 7 → output 21.
- Random `sm_tready`/`ss_tvalid` gaps over a 400-sample run, plus tlast asserted early on sample 10. Require:
  - all outputs match the golden model;
  - `tlast_err`=1;
  - `ap_done`=1 after sample 400.
- Assert `axis_rst` during the MAC of sample 3. Require:
  - all outputs at their reset values the next cycle;
  - `ap_idle`=1;
  - coef readback 0.
